// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and parameter limits for the debounce bank
package debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int WINDOW_MIN = 2;
  localparam int WINDOW_MAX = 65535;

  function automatic bit window_ok(input int window);
    return (window >= WINDOW_MIN) && (window <= WINDOW_MAX);
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// rtl/debounce_bank_if.sv - pin-side inputs and debounced outputs of the bank
interface debounce_bank_if #(
  parameter int N = 18
);

  logic         tick;
  logic [N-1:0] din;
  logic [N-1:0] dout;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         any_change;

  modport master (
    output tick,
    output din,
    input  dout,
    input  rise,
    input  fall,
    input  any_change
  );

  modport slave (
    input  tick,
    input  din,
    output dout,
    output rise,
    output fall,
    output any_change
  );

endinterface

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounced channel: synchroniser, window FSM, edge pulses
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   WINDOW = 100,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= INIT;
      s2    <= INIT;
      dout  <= INIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
      state <= STABLE;
      count <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE: begin
          // The first tick of the window is consumed here, so PENDING starts at 1.
          if ((s2 != dout) && tick) begin
            state <= PENDING;
            count <= CNT_W'(1);
          end else begin
            count <= '0;
          end
        end
        PENDING: begin
          if (s2 == dout) begin
            state <= STABLE;
            count <= '0;
          end else if (tick) begin
            if (count == CNT_LAST) begin
              dout  <= s2;
              rise  <= s2;
              fall  <= ~s2;
              state <= STABLE;
              count <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - N independent debounced channels with a shared change flag
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   N      = 18,
  parameter int   WINDOW = 100,
  parameter logic INIT   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  debounce_bank_if.slave  bus
);

  if (!window_ok(WINDOW)) begin : g_bad_window
    $error("debounce_bank: WINDOW out of range 2..65535");
  end

  logic [N-1:0] dout_w;
  logic [N-1:0] rise_w;
  logic [N-1:0] fall_w;

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_chan #(
      .WINDOW (WINDOW),
      .INIT   (INIT)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .tick (bus.tick),
      .din  (bus.din[i]),
      .dout (dout_w[i]),
      .rise (rise_w[i]),
      .fall (fall_w[i])
    );
  end

  assign bus.dout       = dout_w;
  assign bus.rise       = rise_w;
  assign bus.fall       = fall_w;
  // Built only from registered pulses, so there is no path from din or tick.
  assign bus.any_change = |(rise_w | fall_w);

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel switch/button debouncer, the successor to the single-bit, fixed-window debouncer used on the board's slide switches. It synchronises N asynchronous inputs, filters each with a programmable calming window counted in tick strobes, and emits debounced levels plus one-cycle rise/fall pulses for downstream game/control FSMs. It sits directly behind the board I/O pins and feeds all logic that reads SW/KEY.

## Interface
- N, default 18: number of channels.
- WINDOW, default 100: ticks an input must hold a new value before it is accepted; legal range 2..65535.
- INIT, default 1'b0: reset/initial level of every channel (switches idle off).
- CNT_W, localparam $clog2(WINDOW): counter width per channel.
- clk  in  1  system clock; the block has one clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  sample strobe; tie to 1 to count clk cycles, or drive from a prescaler.
- din  in  N  raw asynchronous switch/button levels.
- dout  out  N  debounced levels.
- rise  out  N  one-cycle pulse when a channel's dout goes 0->1.
- fall  out  N  one-cycle pulse when a channel's dout goes 1->0.
- any_change  out  1  OR of rise|fall (combinational from registered pulses).

## Operation
- Per channel: 2-flop synchroniser s1->s2, then a 2-state FSM (STABLE, PENDING) with a CNT_W-bit counter.
- STABLE: if s2 != dout and tick -> PENDING, count=1; otherwise stay, count=0.
- STABLE, s2 != dout, tick=0: stay STABLE, count=0 (the wait continues next tick).
- PENDING: if s2 == dout -> STABLE, count=0, no output change (bounce rejected).
- PENDING, s2 != dout, tick=0: hold state and count.
- PENDING, s2 != dout, tick=1, count < WINDOW-1: count+1.
- PENDING, s2 != dout, tick=1, count == WINDOW-1: commit: dout<=s2, rise or fall <=1 for that channel, -> STABLE, count=0.
- rise/fall are high exactly one cycle, aligned with the cycle dout first shows the new value; never both high on one channel.
- Channels are fully independent; simultaneous commits on several channels are legal and produce simultaneous pulses.
- Counter never wraps: the commit test at WINDOW-1 bounds it.

## Timing
- Reset (rst=1 at a clk edge): s1, s2, dout = {N{INIT}}; rise, fall = 0; any_change = 0; all FSMs STABLE; counts 0. Takes effect at that edge regardless of state.
- Reset mid-PENDING aborts the pending change with no pulse; after reset, a din that still differs from INIT restarts the full window.
- Latency with tick=1: new din sampled into s1 at edge E0; dout/pulse update at edge E0+WINDOW+1, i.e. WINDOW+2 edges after din first sampled.
- Glitch filter: any s2 excursion that reverts within WINDOW-1 ticks leaves dout unchanged.
- With a prescaled tick, acceptance needs WINDOW ticks, the first counted in STABLE; edges between ticks only check the abort condition.
- No combinational path from din or tick to any output.

## Structure
- Package debounce_pkg: state enum (STABLE, PENDING) and the WINDOW-range check constant.
- Sub-module debounce_chan (one channel: synchroniser, FSM, counter, pulse regs), instantiated N times by a generate loop in debounce_bank; debounce_bank adds only the any_change OR.

## Test plan
- Reset: N=4, WINDOW=4, INIT=0, rst held 3 cycles with din=4'hF -> dout=0, rise=fall=0 throughout reset; after release, dout=4'hF exactly 6 edges after the first sampling edge, rise=4'hF for one cycle.
- Clean press: tick=1, din[0] 0->1 held -> dout[0]=1 at E0+5 (WINDOW=4), rise[0] one cycle, any_change=1 same cycle.
- Bounce: din[1] toggles 1,0,1,0 every cycle for 10 cycles, then 1 -> no output change during bounce; single rise[1] 6 edges after the final stable sample.
- Prescaled: tick every 10 clk, WINDOW=4, din[2] 0->1 -> dout[2] changes on the 4th tick edge after s2 goes high; 3-tick pulse on din[2] -> no change.
- Release and concurrency: channels 0 and 3 go 1->0 on the same cycle -> fall=4'b1001 one cycle, rise=0; rst asserted mid-PENDING on channel 1 -> no pulse, dout[1]=INIT.
